c7bbiu_arb: RTL and testbench

BIU request arbiter that shares one downstream memory port between the instruction fetch unit (read-only) and c7blsu (read and write). It sits between the c7blsu/IFU BIU-side handshakes and the bus/memory port. It keeps one transaction outstanding, picks the requester with fixed priority plus an IFU anti-starvation counter, and steers each response back to the requester that owns it. A response watchdog converts a hung transaction into a bus error.

---
 rtl/c7bbiu_pkg.sv | 25 ++
 rtl/c7bbiu_arb_pick.sv | 41 ++++
 rtl/c7bbiu.sv | 214 +++++++++++++++++++++
 tb/tb_c7bbiu_arb.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c7bbiu_pkg.sv
// c7bbiu_pkg: shared types and defaults for the BIU request arbiter.
//   owner_e  - which requester owns the outstanding transaction
//   state_e  - arbiter FSM states
//   DEF_*    - default watchdog timeout and IFU starvation limit
//   *_W      - counter widths (watchdog and starvation counters are 8 bits)
package c7bbiu_pkg;

    typedef enum logic [1:0] {
        OWN_IFU    = 2'd0,
        OWN_LSU_RD = 2'd1,
        OWN_LSU_WR = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } state_e;

    localparam int unsigned DEF_TIMEOUT      = 255;
    localparam int unsigned DEF_STARVE_LIMIT = 4;
    localparam int unsigned WDOG_W           = 8;
    localparam int unsigned STARVE_W         = 8;

endpackage

// File: rtl/c7bbiu_arb_pick.sv
// c7bbiu_arb_pick: combinational requester picker.
//   ifu_req, lsu_rd_req, lsu_wr_req - pending requests
//   starve_cnt                      - consecutive LSU grants while IFU waited
//   gnt                             - one-hot grant, bit index = owner code
//   owner                           - owner code of the winner (IFU when none)
//   any_req                         - some requester won
module c7bbiu_arb_pick
    import c7bbiu_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                ifu_req,
    input  logic                lsu_rd_req,
    input  logic                lsu_wr_req,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic [2:0]          gnt,
    output owner_e              owner,
    output logic                any_req
);

    always_comb begin
        gnt   = '0;
        owner = OWN_IFU;
        // A starved IFU overrides the normal write > read > IFU order.
        if (ifu_req && (starve_cnt == STARVE_W'(STARVE_LIMIT))) begin
            gnt[0] = 1'b1;
            owner  = OWN_IFU;
        end else if (lsu_wr_req) begin
            gnt[2] = 1'b1;
            owner  = OWN_LSU_WR;
        end else if (lsu_rd_req) begin
            gnt[1] = 1'b1;
            owner  = OWN_LSU_RD;
        end else if (ifu_req) begin
            gnt[0] = 1'b1;
            owner  = OWN_IFU;
        end
        any_req = |gnt;
    end

endmodule

// File: rtl/c7bbiu.sv
// c7bbiu_arb: shares one memory port between the IFU (reads) and the LSU
// (reads and writes), one transaction outstanding at a time.
//   clk, reset          - clock, asynchronous active-high reset
//   ifu_biu_* / biu_ifu_*  - IFU request handshake and read response
//   lsu_biu_* / biu_lsu_*  - LSU read/write request handshakes and responses
//   arb_mem_* / mem_arb_*  - downstream request, grant and responses
// Responses are routed combinationally to the owner in the cycle they
// arrive; a watchdog turns a missing response into a bus error.
module c7bbiu_arb
    import c7bbiu_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ifu_biu_rd_req,
    input  logic [ADDR_W-1:0]   ifu_biu_rd_addr,
    output logic                biu_ifu_rd_ack,
    output logic                biu_ifu_data_valid,
    output logic [DATA_W-1:0]   biu_ifu_data,
    output logic                biu_ifu_buserr,
    input  logic                lsu_biu_rd_req_ls2,
    input  logic [ADDR_W-1:0]   lsu_biu_rd_addr_ls2,
    output logic                biu_lsu_rd_ack_ls2,
    output logic                biu_lsu_data_valid_ls3,
    output logic [DATA_W-1:0]   biu_lsu_data_ls3,
    input  logic                lsu_biu_wr_req_ls2,
    input  logic [ADDR_W-1:0]   lsu_biu_wr_addr_ls2,
    input  logic [DATA_W-1:0]   lsu_biu_wr_data_ls2,
    input  logic [DATA_W/8-1:0] lsu_biu_wr_strb_ls2,
    output logic                biu_lsu_wr_ack_ls2,
    output logic                biu_lsu_wr_done_ls3,
    output logic                biu_lsu_buserr_ls3,
    output logic                arb_mem_req,
    output logic                arb_mem_we,
    output logic [ADDR_W-1:0]   arb_mem_addr,
    output logic [DATA_W-1:0]   arb_mem_wdata,
    output logic [DATA_W/8-1:0] arb_mem_strb,
    input  logic                mem_arb_gnt,
    input  logic                mem_arb_rvalid,
    input  logic [DATA_W-1:0]   mem_arb_rdata,
    input  logic                mem_arb_bvalid,
    input  logic                mem_arb_err
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    state_e                state_q, state_d;
    owner_e                owner_q;
    logic                  we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   strb_q;
    logic [STARVE_W-1:0]   starve_q;
    logic [WDOG_W-1:0]     wdog_q;

    logic [2:0]            pick_gnt;
    owner_e                pick_owner;
    logic                  pick_any;

    logic                  resp_match;
    logic                  wdog_fire;
    logic                  resp_fire;

    c7bbiu_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .ifu_req    (ifu_biu_rd_req),
        .lsu_rd_req (lsu_biu_rd_req_ls2),
        .lsu_wr_req (lsu_biu_wr_req_ls2),
        .starve_cnt (starve_q),
        .gnt        (pick_gnt),
        .owner      (pick_owner),
        .any_req    (pick_any)
    );

    // Only a response of the owner's type counts; the other kind is ignored.
    assign resp_match = (state_q == ST_RESP) &&
                        ((owner_q == OWN_LSU_WR) ? mem_arb_bvalid : mem_arb_rvalid);
    assign wdog_fire  = (state_q == ST_RESP) && (wdog_q == WDOG_W'(TIMEOUT));
    assign resp_fire  = resp_match || wdog_fire;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (pick_any)    state_d = ST_REQ;
            ST_REQ:  if (mem_arb_gnt) state_d = ST_RESP;
            ST_RESP: if (resp_fire)   state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Payload latch, starvation counter and watchdog
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q  <= OWN_IFU;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            starve_q <= '0;
            wdog_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        owner_q <= pick_owner;
                        unique case (pick_owner)
                            OWN_LSU_WR: begin
                                we_q    <= 1'b1;
                                addr_q  <= lsu_biu_wr_addr_ls2;
                                wdata_q <= lsu_biu_wr_data_ls2;
                                strb_q  <= lsu_biu_wr_strb_ls2;
                            end
                            OWN_LSU_RD: begin
                                we_q    <= 1'b0;
                                addr_q  <= lsu_biu_rd_addr_ls2;
                                wdata_q <= '0;
                                strb_q  <= '0;
                            end
                            default: begin
                                we_q    <= 1'b0;
                                addr_q  <= ifu_biu_rd_addr;
                                wdata_q <= '0;
                                strb_q  <= '0;
                            end
                        endcase
                    end
                    // Counts LSU wins only while the IFU is actually waiting.
                    if (!ifu_biu_rd_req || pick_gnt[0]) begin
                        starve_q <= '0;
                    end else if (pick_any && (starve_q < STARVE_MAX)) begin
                        starve_q <= starve_q + STARVE_W'(1);
                    end
                end
                ST_REQ: begin
                    if (mem_arb_gnt) wdog_q <= '0;
                end
                ST_RESP: begin
                    wdog_q <= wdog_q + WDOG_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        biu_ifu_rd_ack         = 1'b0;
        biu_ifu_data_valid     = 1'b0;
        biu_ifu_data           = '0;
        biu_ifu_buserr         = 1'b0;
        biu_lsu_rd_ack_ls2     = 1'b0;
        biu_lsu_data_valid_ls3 = 1'b0;
        biu_lsu_data_ls3       = '0;
        biu_lsu_wr_ack_ls2     = 1'b0;
        biu_lsu_wr_done_ls3    = 1'b0;
        biu_lsu_buserr_ls3     = 1'b0;
        arb_mem_req            = 1'b0;
        arb_mem_we             = 1'b0;
        arb_mem_addr           = '0;
        arb_mem_wdata          = '0;
        arb_mem_strb           = '0;
        unique case (state_q)
            ST_REQ: begin
                arb_mem_req   = 1'b1;
                arb_mem_we    = we_q;
                arb_mem_addr  = addr_q;
                arb_mem_wdata = wdata_q;
                arb_mem_strb  = strb_q;
                if (mem_arb_gnt) begin
                    unique case (owner_q)
                        OWN_LSU_WR: biu_lsu_wr_ack_ls2 = 1'b1;
                        OWN_LSU_RD: biu_lsu_rd_ack_ls2 = 1'b1;
                        default:    biu_ifu_rd_ack     = 1'b1;
                    endcase
                end
            end
            ST_RESP: begin
                if (resp_fire) begin
                    // A real response wins over a watchdog expiry in the same cycle.
                    unique case (owner_q)
                        OWN_LSU_WR: begin
                            biu_lsu_wr_done_ls3 = 1'b1;
                            biu_lsu_buserr_ls3  = resp_match ? mem_arb_err : 1'b1;
                        end
                        OWN_LSU_RD: begin
                            biu_lsu_data_valid_ls3 = 1'b1;
                            biu_lsu_data_ls3       = resp_match ? mem_arb_rdata : '0;
                            biu_lsu_buserr_ls3     = resp_match ? mem_arb_err : 1'b1;
                        end
                        default: begin
                            biu_ifu_data_valid = 1'b1;
                            biu_ifu_data       = resp_match ? mem_arb_rdata : '0;
                            biu_ifu_buserr     = resp_match ? mem_arb_err : 1'b1;
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_c7bbiu_arb.sv
// tb_c7bbiu_arb: scoreboard bench for c7bbiu_arb. The driver plays the three
// requesters and the memory, predicts each bus request, ack and response from
// a transaction-level model, and queues them with the cycle they are due; a
// negedge monitor pops and compares whenever the DUT presents one.
module tb_c7bbiu_arb;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SL = 4;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ifu_biu_rd_req = 1'b0;
    logic [AW-1:0] ifu_biu_rd_addr = '0;
    logic          biu_ifu_rd_ack, biu_ifu_data_valid, biu_ifu_buserr;
    logic [DW-1:0] biu_ifu_data;
    logic          lsu_biu_rd_req_ls2 = 1'b0;
    logic [AW-1:0] lsu_biu_rd_addr_ls2 = '0;
    logic          biu_lsu_rd_ack_ls2, biu_lsu_data_valid_ls3;
    logic [DW-1:0] biu_lsu_data_ls3;
    logic          lsu_biu_wr_req_ls2 = 1'b0;
    logic [AW-1:0] lsu_biu_wr_addr_ls2 = '0;
    logic [DW-1:0] lsu_biu_wr_data_ls2 = '0;
    logic [DW/8-1:0] lsu_biu_wr_strb_ls2 = '0;
    logic          biu_lsu_wr_ack_ls2, biu_lsu_wr_done_ls3, biu_lsu_buserr_ls3;
    logic          arb_mem_req, arb_mem_we;
    logic [AW-1:0] arb_mem_addr;
    logic [DW-1:0] arb_mem_wdata;
    logic [DW/8-1:0] arb_mem_strb;
    logic          mem_arb_gnt = 1'b0;
    logic          mem_arb_rvalid = 1'b0;
    logic [DW-1:0] mem_arb_rdata = '0;
    logic          mem_arb_bvalid = 1'b0;
    logic          mem_arb_err = 1'b0;

    c7bbiu_arb #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .ifu_biu_rd_req(ifu_biu_rd_req), .ifu_biu_rd_addr(ifu_biu_rd_addr),
        .biu_ifu_rd_ack(biu_ifu_rd_ack), .biu_ifu_data_valid(biu_ifu_data_valid),
        .biu_ifu_data(biu_ifu_data), .biu_ifu_buserr(biu_ifu_buserr),
        .lsu_biu_rd_req_ls2(lsu_biu_rd_req_ls2), .lsu_biu_rd_addr_ls2(lsu_biu_rd_addr_ls2),
        .biu_lsu_rd_ack_ls2(biu_lsu_rd_ack_ls2), .biu_lsu_data_valid_ls3(biu_lsu_data_valid_ls3),
        .biu_lsu_data_ls3(biu_lsu_data_ls3),
        .lsu_biu_wr_req_ls2(lsu_biu_wr_req_ls2), .lsu_biu_wr_addr_ls2(lsu_biu_wr_addr_ls2),
        .lsu_biu_wr_data_ls2(lsu_biu_wr_data_ls2), .lsu_biu_wr_strb_ls2(lsu_biu_wr_strb_ls2),
        .biu_lsu_wr_ack_ls2(biu_lsu_wr_ack_ls2), .biu_lsu_wr_done_ls3(biu_lsu_wr_done_ls3),
        .biu_lsu_buserr_ls3(biu_lsu_buserr_ls3),
        .arb_mem_req(arb_mem_req), .arb_mem_we(arb_mem_we), .arb_mem_addr(arb_mem_addr),
        .arb_mem_wdata(arb_mem_wdata), .arb_mem_strb(arb_mem_strb),
        .mem_arb_gnt(mem_arb_gnt), .mem_arb_rvalid(mem_arb_rvalid),
        .mem_arb_rdata(mem_arb_rdata), .mem_arb_bvalid(mem_arb_bvalid),
        .mem_arb_err(mem_arb_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; bit we; bit [AW-1:0] addr; bit [DW-1:0] wdata; bit [DW/8-1:0] strb; } bus_t;
    typedef struct { int cyc; int own; } ack_t;
    typedef struct { int cyc; int own; bit [DW-1:0] data; bit err; } resp_t;

    bus_t  bus_q[$];
    ack_t  ack_q[$];
    resp_t resp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Requester model: 0 = IFU, 1 = LSU read, 2 = LSU write
    bit            pend[3];
    bit            keep[3];
    bit [AW-1:0]   addr_m[3];
    bit [DW-1:0]   wdata_m;
    bit [DW/8-1:0] strb_m;
    int            starve_m = 0;
    bit            exp_req_lvl = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_inputs();
        ifu_biu_rd_req      = pend[0];
        ifu_biu_rd_addr     = addr_m[0];
        lsu_biu_rd_req_ls2  = pend[1];
        lsu_biu_rd_addr_ls2 = addr_m[1];
        lsu_biu_wr_req_ls2  = pend[2];
        lsu_biu_wr_addr_ls2 = addr_m[2];
        lsu_biu_wr_data_ls2 = wdata_m;
        lsu_biu_wr_strb_ls2 = strb_m;
    endtask

    task automatic new_req(input int i);
        pend[i]   = 1'b1;
        addr_m[i] = $urandom;
        if (i == 2) begin
            wdata_m = {$urandom, $urandom};
            strb_m  = 8'($urandom);
        end
    endtask

    function automatic logic [255:0] all_outputs();
        return {biu_ifu_rd_ack, biu_ifu_data_valid, biu_ifu_data, biu_ifu_buserr,
                biu_lsu_rd_ack_ls2, biu_lsu_data_valid_ls3, biu_lsu_data_ls3,
                biu_lsu_wr_ack_ls2, biu_lsu_wr_done_ls3, biu_lsu_buserr_ls3,
                arb_mem_req, arb_mem_we, arb_mem_addr, arb_mem_wdata, arb_mem_strb};
    endfunction

    // Fixed priority: starved IFU, then write, then read, then IFU.
    function automatic int pick_model();
        if (pend[0] && starve_m == SL) return 0;
        if (pend[2]) return 2;
        if (pend[1]) return 1;
        return 0;
    endfunction

    // Called in an idle cycle with at least one request pending.
    task automatic txn(input int gd, input int rdly, input bit wrong, input bit tmo,
                       input bit rst, input bit [DW-1:0] rdata, input bit err);
        int    w;
        bus_t  b;
        ack_t  a;
        resp_t r;
        w = pick_model();
        if (w == 0)       starve_m = 0;
        else if (pend[0]) starve_m = (starve_m < SL) ? starve_m + 1 : SL;
        else              starve_m = 0;
        b.cyc   = cyc + 1 + gd;
        b.we    = (w == 2);
        b.addr  = addr_m[w];
        b.wdata = (w == 2) ? wdata_m : '0;
        b.strb  = (w == 2) ? strb_m : '0;
        bus_q.push_back(b);
        a.cyc = cyc + 1 + gd;
        a.own = w;
        ack_q.push_back(a);
        tick();
        exp_req_lvl = 1'b1;
        // Payload wiggles after latching must not reach the bus.
        case (w)
            0: ifu_biu_rd_addr = $urandom;
            1: lsu_biu_rd_addr_ls2 = $urandom;
            default: begin
                lsu_biu_wr_addr_ls2 = $urandom;
                lsu_biu_wr_data_ls2 = {$urandom, $urandom};
                lsu_biu_wr_strb_ls2 = 8'($urandom);
            end
        endcase
        repeat (gd) tick();
        mem_arb_gnt = 1'b1;
        tick();
        mem_arb_gnt = 1'b0;
        exp_req_lvl = 1'b0;
        pend[w] = 1'b0;
        apply_inputs();
        if (rst) begin
            repeat (2) tick();
            reset = 1'b1;
            #1;
            chk("reset_in_resp_outputs", all_outputs(), '0);
            repeat (2) tick();
            reset    = 1'b0;
            starve_m = 0;
            for (int i = 0; i < 3; i++) pend[i] = 1'b0;
            apply_inputs();
            tick();
        end else if (tmo) begin
            repeat (TO) tick();
            r.cyc = cyc; r.own = w; r.data = '0; r.err = 1'b1;
            resp_q.push_back(r);
            tick();
        end else begin
            for (int i = 0; i < rdly; i++) begin
                if (wrong && ($urandom_range(0, 1) == 1)) begin
                    mem_arb_rvalid = (w == 2);
                    mem_arb_bvalid = (w != 2);
                    mem_arb_rdata  = {$urandom, $urandom};
                    mem_arb_err    = 1'($urandom);
                end
                tick();
                mem_arb_rvalid = 1'b0;
                mem_arb_bvalid = 1'b0;
            end
            mem_arb_rvalid = (w != 2);
            mem_arb_bvalid = (w == 2);
            mem_arb_rdata  = rdata;
            mem_arb_err    = err;
            r.cyc = cyc; r.own = w; r.data = (w != 2) ? rdata : '0; r.err = err;
            resp_q.push_back(r);
            tick();
            mem_arb_rvalid = 1'b0;
            mem_arb_bvalid = 1'b0;
            mem_arb_err    = 1'b0;
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!reset) begin
            bus_t  b;
            ack_t  a;
            resp_t r;
            logic [2:0]    flags;
            logic          aerr;
            logic [DW-1:0] adata;
            chk("mem_req_level", 256'(arb_mem_req), 256'(exp_req_lvl));
            if (arb_mem_req && mem_arb_gnt) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_bus_req", 256'(1), 256'(0));
                end else begin
                    b = bus_q.pop_front();
                    chk("bus_req", {cyc, arb_mem_we, arb_mem_addr, arb_mem_wdata, arb_mem_strb},
                                   {b.cyc, b.we, b.addr, b.wdata, b.strb});
                end
            end
            if (biu_ifu_rd_ack || biu_lsu_rd_ack_ls2 || biu_lsu_wr_ack_ls2) begin
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", 256'(1), 256'(0));
                end else begin
                    a = ack_q.pop_front();
                    chk("ack", {cyc, biu_ifu_rd_ack, biu_lsu_rd_ack_ls2, biu_lsu_wr_ack_ls2},
                               {a.cyc, a.own == 0, a.own == 1, a.own == 2});
                end
            end
            flags = {biu_ifu_data_valid, biu_lsu_data_valid_ls3, biu_lsu_wr_done_ls3};
            if (|flags) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_resp", 256'(flags), 256'(0));
                end else begin
                    r = resp_q.pop_front();
                    aerr  = (r.own == 0) ? biu_ifu_buserr : biu_lsu_buserr_ls3;
                    adata = (r.own == 0) ? biu_ifu_data :
                            (r.own == 1) ? biu_lsu_data_ls3 : '0;
                    chk("resp", {cyc, flags, aerr, adata},
                                {r.cyc, r.own == 0, r.own == 1, r.own == 2, r.err, r.data});
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            pend[i] = 1'b0; keep[i] = 1'b0; addr_m[i] = '0;
        end
        wdata_m = '0;
        strb_m  = '0;
        repeat (3) tick();
        chk("reset_outputs", all_outputs(), '0);
        reset = 1'b0;
        tick();

        // LSU read, zero-wait memory
        pend[1] = 1'b1; addr_m[1] = 32'h1004; apply_inputs();
        txn(0, 0, 0, 0, 0, 64'h123456789ABCDEF0, 0);

        // LSU write with bus error
        pend[2] = 1'b1; addr_m[2] = 32'h2000; wdata_m = 64'hAA << 16; strb_m = 8'h04;
        apply_inputs();
        txn(0, 1, 0, 0, 0, 64'h0, 1);

        // Simultaneous LSU read and write
        pend[1] = 1'b1; addr_m[1] = 32'h3008;
        pend[2] = 1'b1; addr_m[2] = 32'h3010; wdata_m = 64'h0123_4567_89AB_CDEF; strb_m = 8'hFF;
        apply_inputs();
        txn(1, 0, 0, 0, 0, 64'h5555_AAAA_5555_AAAA, 0);
        apply_inputs();
        txn(0, 2, 1, 0, 0, 64'hDEAD_BEEF_0000_1111, 0);

        // IFU and LSU read both requesting continuously
        keep[0] = 1'b1; keep[1] = 1'b1;
        for (int n = 0; n < 12; n++) begin
            if (!pend[0]) begin pend[0] = 1'b1; addr_m[0] = 32'h100 + 32'(n); end
            if (!pend[1]) begin pend[1] = 1'b1; addr_m[1] = 32'h200 + 32'(n); end
            apply_inputs();
            txn(0, 0, 0, 0, 0, {$urandom, $urandom}, 0);
        end
        keep[0] = 1'b0; keep[1] = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < 3; i++)
                if (!pend[i] && ($urandom_range(0, 2) == 0)) new_req(i);
            apply_inputs();
            if (!(pend[0] || pend[1] || pend[2])) begin
                starve_m = 0;
                tick();
            end else begin
                txn($urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), 0, 0,
                    {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
            end
        end
        while (pend[0] || pend[1] || pend[2]) begin
            apply_inputs();
            txn(0, 0, 0, 0, 0, {$urandom, $urandom}, 0);
        end

        // Watchdog on an IFU read, then a late rvalid that must be dropped
        pend[0] = 1'b1; addr_m[0] = 32'h4000; apply_inputs();
        txn(0, 0, 0, 1, 0, 64'h0, 0);
        repeat (9) tick();
        mem_arb_rvalid = 1'b1; mem_arb_rdata = 64'hFFFF_0000_FFFF_0000;
        tick();
        mem_arb_rvalid = 1'b0;
        repeat (2) tick();

        // Reset while an LSU read is outstanding, then a normal IFU read
        pend[1] = 1'b1; addr_m[1] = 32'h5000; apply_inputs();
        txn(0, 0, 0, 0, 1, 64'h0, 0);
        pend[0] = 1'b1; addr_m[0] = 32'h6000; apply_inputs();
        txn(0, 1, 0, 0, 0, 64'hCAFE_F00D_1234_5678, 0);
        repeat (3) tick();

        chk("bus_queue_drained", 256'(bus_q.size()), 256'(0));
        chk("ack_queue_drained", 256'(ack_q.size()), 256'(0));
        chk("resp_queue_drained", 256'(resp_q.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
